// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
// Bundles every handshake and bus signal of the memory bus arbiter.
//   CPU master : cpuReq, cpuWrite, cpuAddr[31:0], cpuWData[31:0] (to arbiter)
//                cpuAck, cpuRData[31:0], cpuErr                   (from arbiter)
//   DMA master : dmaReq, dmaWrite, dmaAddr[31:0], dmaWData[31:0] (to arbiter)
//                dmaAck, dmaRData[31:0], dmaErr                   (from arbiter)
//   Bus side   : busAddr[31:0], busWData[31:0], busWrite, busRead (from arbiter)
//                busRData[31:0], decBank[1:0], decInvalid         (to arbiter)
//   Status     : busy, grantDma                                   (from arbiter)
// Modport slave is the arbiter's view; modport master is the environment's view.
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if;
   logic        cpuReq;
   logic        cpuWrite;
   logic [31:0] cpuAddr;
   logic [31:0] cpuWData;
   logic        cpuAck;
   logic [31:0] cpuRData;
   logic        cpuErr;

   logic        dmaReq;
   logic        dmaWrite;
   logic [31:0] dmaAddr;
   logic [31:0] dmaWData;
   logic        dmaAck;
   logic [31:0] dmaRData;
   logic        dmaErr;

   logic [31:0] busAddr;
   logic [31:0] busWData;
   logic        busWrite;
   logic        busRead;
   logic [31:0] busRData;
   logic [1:0]  decBank;
   logic        decInvalid;

   logic        busy;
   logic        grantDma;

   modport slave (
      input  cpuReq, cpuWrite, cpuAddr, cpuWData,
      output cpuAck, cpuRData, cpuErr,
      input  dmaReq, dmaWrite, dmaAddr, dmaWData,
      output dmaAck, dmaRData, dmaErr,
      output busAddr, busWData, busWrite, busRead,
      input  busRData, decBank, decInvalid,
      output busy, grantDma
   );

   modport master (
      output cpuReq, cpuWrite, cpuAddr, cpuWData,
      input  cpuAck, cpuRData, cpuErr,
      output dmaReq, dmaWrite, dmaAddr, dmaWData,
      input  dmaAck, dmaRData, dmaErr,
      input  busAddr, busWData, busWrite, busRead,
      output busRData, decBank, decInvalid,
      input  busy, grantDma
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Arbitrates a CPU master and a DMA master onto a single memory bus. A granted
// request is latched, presented on the bus for the bank latency (1, 2 or 4
// cycles, or 1 cycle for an invalid decode), then completed with a one-cycle
// Ack to the owning master. Ties are broken round-robin; CPU wins the first.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mem_bus_arbiter_if.slave -- CPU/DMA handshakes, bus side, status
// All outputs are flops (bus address/data are the latched request registers).
// -----------------------------------------------------------------------------
module mem_bus_arbiter (
   input  logic               clk,
   input  logic               rst,
   mem_bus_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } stateT;

   stateT       state;
   stateT       nextState;

   logic        lastGnt;      // owner of the previous grant: 0=CPU, 1=DMA
   logic        gnt;          // owner of the transfer in progress
   logic        wrLat;
   logic [31:0] addrLat;
   logic [31:0] wdataLat;
   logic [1:0]  cnt;
   logic        firstCyc;     // high during the first ACCESS cycle

   logic        reqAny;
   logic        pickDma;
   logic        pickWrite;
   logic [1:0]  cntEff;
   logic        accInvalid;
   logic        accDone;
   logic [31:0] rdataCapture;

   logic        xferDma;
   logic        xferWrite;
   logic        busyNext;
   logic        grantDmaNext;
   logic        busReadNext;
   logic        busWriteNext;
   logic        cpuAckNext;
   logic        dmaAckNext;
   logic        cpuErrNext;
   logic        dmaErrNext;
   logic [31:0] cpuRDataNext;
   logic [31:0] dmaRDataNext;

   // Remaining ACCESS cycles after the first one, per decoder bank.
   function automatic logic [1:0] bankLatency(input logic [1:0] bank);
      logic [1:0] lat;
      case (bank)
         2'd0:    lat = 2'd0;
         2'd1:    lat = 2'd1;
         2'd2:    lat = 2'd3;
         default: lat = 2'd0;
      endcase
      return lat;
   endfunction

   // Arbitration choice and access-progress decode.
   always_comb begin
      reqAny = bus.cpuReq | bus.dmaReq;
      if (bus.cpuReq && bus.dmaReq) begin
         pickDma = ~lastGnt;
      end else begin
         pickDma = bus.dmaReq;
      end
      if (pickDma) begin
         pickWrite = bus.dmaWrite;
      end else begin
         pickWrite = bus.cpuWrite;
      end
      // The counter is only loaded at the end of the first ACCESS cycle, so
      // during that cycle the bank latency stands in for it.
      if (firstCyc) begin
         cntEff = bankLatency(bus.decBank);
      end else begin
         cntEff = cnt;
      end
      accInvalid = firstCyc & (bus.decInvalid | (bus.decBank == 2'd3));
      accDone    = accInvalid | (cntEff == 2'd0);
      if (accInvalid || wrLat) begin
         rdataCapture = 32'd0;
      end else begin
         rdataCapture = bus.busRData;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (reqAny) begin
               nextState = ACCESS;
            end else begin
               nextState = IDLE;
            end
         end
         ACCESS: begin
            if (accDone) begin
               nextState = DONE;
            end else begin
               nextState = ACCESS;
            end
         end
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Output decode: values the output flops take at the next edge, derived
   // from the state being entered so that outputs line up with that state.
   always_comb begin
      if (state == IDLE) begin
         xferDma   = pickDma;
         xferWrite = pickWrite;
      end else begin
         xferDma   = gnt;
         xferWrite = wrLat;
      end
      busyNext     = (nextState != IDLE);
      grantDmaNext = busyNext & xferDma;
      busReadNext  = (nextState == ACCESS) & ~xferWrite;
      busWriteNext = (nextState == ACCESS) &  xferWrite;
      // DONE is only entered from ACCESS, so gnt already names the owner.
      cpuAckNext   = (nextState == DONE) & ~gnt;
      dmaAckNext   = (nextState == DONE) &  gnt;
      cpuErrNext   = cpuAckNext & accInvalid;
      dmaErrNext   = dmaAckNext & accInvalid;
      if (cpuAckNext) begin
         cpuRDataNext = rdataCapture;
      end else begin
         cpuRDataNext = 32'd0;
      end
      if (dmaAckNext) begin
         dmaRDataNext = rdataCapture;
      end else begin
         dmaRDataNext = 32'd0;
      end
   end

   // Request latch, round-robin history and latency counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lastGnt  <= 1'b1;
         gnt      <= 1'b0;
         wrLat    <= 1'b0;
         addrLat  <= 32'd0;
         wdataLat <= 32'd0;
         cnt      <= 2'd0;
         firstCyc <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (reqAny) begin
                  gnt      <= pickDma;
                  lastGnt  <= pickDma;
                  wrLat    <= pickWrite;
                  addrLat  <= pickDma ? bus.dmaAddr  : bus.cpuAddr;
                  wdataLat <= pickDma ? bus.dmaWData : bus.cpuWData;
                  cnt      <= 2'd0;
                  firstCyc <= 1'b1;
               end
            end
            ACCESS: begin
               firstCyc <= 1'b0;
               if (!accDone) begin
                  cnt <= cntEff - 2'd1;
               end
            end
            DONE: begin
               firstCyc <= 1'b0;
            end
            default: begin
               firstCyc <= 1'b0;
            end
         endcase
      end
   end

   // Output flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.busy     <= 1'b0;
         bus.grantDma <= 1'b0;
         bus.busRead  <= 1'b0;
         bus.busWrite <= 1'b0;
         bus.cpuAck   <= 1'b0;
         bus.dmaAck   <= 1'b0;
         bus.cpuErr   <= 1'b0;
         bus.dmaErr   <= 1'b0;
         bus.cpuRData <= 32'd0;
         bus.dmaRData <= 32'd0;
      end else begin
         bus.busy     <= busyNext;
         bus.grantDma <= grantDmaNext;
         bus.busRead  <= busReadNext;
         bus.busWrite <= busWriteNext;
         bus.cpuAck   <= cpuAckNext;
         bus.dmaAck   <= dmaAckNext;
         bus.cpuErr   <= cpuErrNext;
         bus.dmaErr   <= dmaErrNext;
         bus.cpuRData <= cpuRDataNext;
         bus.dmaRData <= dmaRDataNext;
      end
   end

   // The latched request registers drive the bus directly, so the address
   // and store data cannot move while an access is in progress.
   assign bus.busAddr  = addrLat;
   assign bus.busWData = wdataLat;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter. Cycle 0 is the IDLE cycle in which a
// request is first presented; "cycle n" is observed 1 ns after the n-th
// following rising edge.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

   logic clk;
   logic rst;
   int   nAssert;
   int   nFail;
   int   wrCycles;

   mem_bus_arbiter_if ifc ();

   mem_bus_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Directed sequence.
   initial begin
      nAssert        = 0;
      nFail          = 0;
      wrCycles       = 0;
      rst            = 1'b1;
      ifc.cpuReq     = 1'b0;
      ifc.cpuWrite   = 1'b0;
      ifc.cpuAddr    = 32'd0;
      ifc.cpuWData   = 32'd0;
      ifc.dmaReq     = 1'b0;
      ifc.dmaWrite   = 1'b0;
      ifc.dmaAddr    = 32'd0;
      ifc.dmaWData   = 32'd0;
      ifc.busRData   = 32'd0;
      ifc.decBank    = 2'd0;
      ifc.decInvalid = 1'b0;
      step();
      step();

      // Reset state.
      chk1 ("rst_busy",     ifc.busy,     1'b0);
      chk1 ("rst_grantDma", ifc.grantDma, 1'b0);
      chk1 ("rst_busRead",  ifc.busRead,  1'b0);
      chk1 ("rst_busWrite", ifc.busWrite, 1'b0);
      chk1 ("rst_cpuAck",   ifc.cpuAck,   1'b0);
      chk32("rst_busAddr",  ifc.busAddr,  32'd0);
      rst = 1'b0;

      // A: CPU load, bank 0.
      ifc.cpuReq   = 1'b1;
      ifc.cpuWrite = 1'b0;
      ifc.cpuAddr  = 32'h1001_0004;
      ifc.cpuWData = 32'h1234_5678;
      ifc.decBank  = 2'd0;
      ifc.busRData = 32'hDEAD_BEEF;
      step();
      chk1 ("A_c1_busRead",  ifc.busRead,  1'b1);
      chk1 ("A_c1_busWrite", ifc.busWrite, 1'b0);
      chk32("A_c1_busAddr",  ifc.busAddr,  32'h1001_0004);
      chk1 ("A_c1_busy",     ifc.busy,     1'b1);
      chk1 ("A_c1_cpuAck",   ifc.cpuAck,   1'b0);
      step();
      chk1 ("A_c2_cpuAck",   ifc.cpuAck,   1'b1);
      chk32("A_c2_cpuRData", ifc.cpuRData, 32'hDEAD_BEEF);
      chk1 ("A_c2_cpuErr",   ifc.cpuErr,   1'b0);
      chk1 ("A_c2_dmaAck",   ifc.dmaAck,   1'b0);
      chk32("A_c2_dmaRData", ifc.dmaRData, 32'd0);
      chk1 ("A_c2_busRead",  ifc.busRead,  1'b0);
      ifc.cpuReq = 1'b0;
      step();
      chk1 ("A_c3_busy",     ifc.busy,     1'b0);
      chk1 ("A_c3_cpuAck",   ifc.cpuAck,   1'b0);

      // B: DMA store, bank 2.
      ifc.dmaReq   = 1'b1;
      ifc.dmaWrite = 1'b1;
      ifc.dmaAddr  = 32'hFFFF_0008;
      ifc.dmaWData = 32'hCAFE_F00D;
      ifc.decBank  = 2'd2;
      ifc.busRData = 32'h5555_5555;
      step();
      chk1 ("B_c1_grantDma", ifc.grantDma, 1'b1);
      chk1 ("B_c1_busRead",  ifc.busRead,  1'b0);
      chk32("B_c1_busAddr",  ifc.busAddr,  32'hFFFF_0008);
      chk32("B_c1_busWData", ifc.busWData, 32'hCAFE_F00D);
      wrCycles = int'(ifc.busWrite);
      for (int i = 2; i <= 4; i++) begin
         step();
         wrCycles += int'(ifc.busWrite);
         chk1("B_early_dmaAck", ifc.dmaAck, 1'b0);
      end
      step();
      chk32("B_wrCycles",    32'(wrCycles), 32'd4);
      chk1 ("B_c5_dmaAck",   ifc.dmaAck,   1'b1);
      chk32("B_c5_dmaRData", ifc.dmaRData, 32'd0);
      chk1 ("B_c5_dmaErr",   ifc.dmaErr,   1'b0);
      chk1 ("B_c5_cpuAck",   ifc.cpuAck,   1'b0);
      chk1 ("B_c5_busWrite", ifc.busWrite, 1'b0);
      ifc.dmaReq   = 1'b0;
      ifc.dmaWrite = 1'b0;
      step();

      // C: both masters held high after reset -> CPU, DMA, CPU.
      rst = 1'b1;
      step();
      ifc.cpuReq   = 1'b1;
      ifc.cpuWrite = 1'b0;
      ifc.cpuAddr  = 32'h1001_0000;
      ifc.dmaReq   = 1'b1;
      ifc.dmaWrite = 1'b0;
      ifc.dmaAddr  = 32'h1002_0000;
      ifc.decBank  = 2'd0;
      ifc.busRData = 32'h1111_1111;
      rst = 1'b0;
      step();
      chk1 ("C_c1_grantDma", ifc.grantDma, 1'b0);
      chk32("C_c1_busAddr",  ifc.busAddr,  32'h1001_0000);
      step();
      chk1 ("C_c2_cpuAck",   ifc.cpuAck,   1'b1);
      chk1 ("C_c2_dmaAck",   ifc.dmaAck,   1'b0);
      step();
      chk1 ("C_c3_busy",     ifc.busy,     1'b0);
      chk1 ("C_c3_busRead",  ifc.busRead,  1'b0);
      step();
      chk1 ("C_c4_grantDma", ifc.grantDma, 1'b1);
      chk32("C_c4_busAddr",  ifc.busAddr,  32'h1002_0000);
      step();
      chk1 ("C_c5_dmaAck",   ifc.dmaAck,   1'b1);
      chk1 ("C_c5_cpuAck",   ifc.cpuAck,   1'b0);
      chk32("C_c5_dmaRData", ifc.dmaRData, 32'h1111_1111);
      step();
      chk1 ("C_c6_busy",     ifc.busy,     1'b0);
      step();
      chk1 ("C_c7_grantDma", ifc.grantDma, 1'b0);
      chk1 ("C_c7_busy",     ifc.busy,     1'b1);
      step();
      chk1 ("C_c8_cpuAck",   ifc.cpuAck,   1'b1);
      ifc.cpuReq = 1'b0;
      ifc.dmaReq = 1'b0;
      step();

      // D: CPU load with an invalid decode.
      ifc.cpuReq     = 1'b1;
      ifc.cpuWrite   = 1'b0;
      ifc.cpuAddr    = 32'h0000_0000;
      ifc.decInvalid = 1'b1;
      ifc.busRData   = 32'h7777_7777;
      step();
      chk1 ("D_c1_busRead",  ifc.busRead,  1'b1);
      step();
      chk1 ("D_c2_cpuAck",   ifc.cpuAck,   1'b1);
      chk1 ("D_c2_cpuErr",   ifc.cpuErr,   1'b1);
      chk1 ("D_c2_busRead",  ifc.busRead,  1'b0);
      chk32("D_c2_cpuRData", ifc.cpuRData, 32'd0);
      ifc.cpuReq     = 1'b0;
      ifc.decInvalid = 1'b0;
      step();

      // E: VGA load, bank 1, master inputs disturbed during ACCESS.
      ifc.cpuReq   = 1'b1;
      ifc.cpuWrite = 1'b0;
      ifc.cpuAddr  = 32'h0000_B800;
      ifc.decBank  = 2'd1;
      ifc.busRData = 32'h00AA_55FF;
      step();
      chk32("E_c1_busAddr",  ifc.busAddr,  32'h0000_B800);
      ifc.cpuAddr  = 32'h1234_5678;
      ifc.cpuWrite = 1'b1;
      ifc.cpuWData = 32'hFFFF_FFFF;
      step();
      chk32("E_c2_busAddr",  ifc.busAddr,  32'h0000_B800);
      chk1 ("E_c2_busRead",  ifc.busRead,  1'b1);
      chk1 ("E_c2_busWrite", ifc.busWrite, 1'b0);
      chk1 ("E_c2_cpuAck",   ifc.cpuAck,   1'b0);
      step();
      chk1 ("E_c3_cpuAck",   ifc.cpuAck,   1'b1);
      chk32("E_c3_cpuRData", ifc.cpuRData, 32'h00AA_55FF);
      ifc.cpuReq   = 1'b0;
      ifc.cpuWrite = 1'b0;
      step();

      // F: reset pulsed during a bank 2 access, request held throughout.
      ifc.cpuReq   = 1'b1;
      ifc.cpuWrite = 1'b0;
      ifc.cpuAddr  = 32'hFFFF_0010;
      ifc.decBank  = 2'd2;
      ifc.busRData = 32'h55AA_55AA;
      step();
      step();
      chk1 ("F_pre_busy",    ifc.busy,     1'b1);
      rst = 1'b1;
      #1;
      chk1 ("F_rst_busy",    ifc.busy,     1'b0);
      chk1 ("F_rst_busRead", ifc.busRead,  1'b0);
      chk32("F_rst_busAddr", ifc.busAddr,  32'd0);
      step();
      chk1 ("F_rst_cpuAck",  ifc.cpuAck,   1'b0);
      chk1 ("F_rst_busy2",   ifc.busy,     1'b0);
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         chk1("F_early_cpuAck", ifc.cpuAck, 1'b0);
      end
      step();
      chk1 ("F_c5_cpuAck",   ifc.cpuAck,   1'b1);
      chk32("F_c5_cpuRData", ifc.cpuRData, 32'h55AA_55AA);
      ifc.cpuReq = 1'b0;
      step();
      chk1 ("F_end_busy",    ifc.busy,     1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  async active-high reset.
REQ-002 The block SHALL have these CPU master ports: cpuReq in 1 request; cpuWrite in 1 (1=store, 0=load); cpuAddr in 32 virtual address; cpuWData in 32 store data; cpuAck out 1 one-cycle completion pulse; cpuRData out 32 load data; cpuErr out 1 error flag, valid with cpuAck.
REQ-003 The block SHALL have these DMA master ports: dmaReq, dmaWrite, dmaAddr, dmaWData, dmaAck, dmaRData, dmaErr, with the same directions, widths and meanings as the CPU ports.
REQ-004 The block SHALL have these bus-side ports: busAddr out 32 to the address decoder; busWData out 32; busWrite out 1; busRead out 1; busRData in 32 from the memory mux; decBank in 2 decoder bank (0 data mem, 1 VGA, 2 IO); decInvalid in 1 decoder invalid flag.
REQ-005 The block SHALL have these status ports: busy out 1, high in any state other than IDLE; grantDma out 1, high while the current transfer belongs to DMA.

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-007 In IDLE with no request pending, the FSM SHALL stay in IDLE with busRead=busWrite=0.
REQ-008 In IDLE with exactly one request pending, the FSM SHALL grant that master, latch its addr/wdata/write into internal registers, and go to ACCESS.
REQ-009 In IDLE with both requests pending, the FSM SHALL grant round-robin: it grants the master not granted last, using register lastGnt (0=CPU, 1=DMA), and updates lastGnt on every grant.
REQ-010 In ACCESS, busAddr/busWData SHALL come from the latched registers, busWrite SHALL equal the latched write bit and busRead its inverse, so the bus stays stable for the whole access regardless of master inputs.
REQ-011 On the first ACCESS cycle, the block SHALL sample decInvalid and decBank; if decInvalid=1 or decBank=3, it SHALL record err=1 and go to DONE next cycle.
REQ-012 If the access is valid, a down-counter SHALL be loaded with the bank latency minus 1: bank0=0, bank1=1, bank2=3, so ACCESS lasts 1, 2 or 4 cycles.
REQ-013 When the counter is 0 in ACCESS, a load SHALL capture busRData into the read-data register, a store SHALL set it to 0, and the FSM SHALL go to DONE.
REQ-014 In DONE, the block SHALL assert the granted master's Ack for exactly one cycle, with RData and Err driven from registers, and return to IDLE.
REQ-015 The non-granted master's Ack, Err and RData SHALL be 0 at all times.
REQ-016 A master SHALL hold Req and its address, data and write bit until it sees Ack; Req still high in the IDLE after DONE is a new request and is arbitrated normally.
REQ-017 End-to-end latency from a Req sampled in IDLE (cycle 0) to Ack SHALL be 2, 3 or 5 cycles for bank 0, 1 or 2, and 2 cycles for an invalid address.
REQ-018 Changes on Req or master inputs during ACCESS or DONE SHALL have no effect on the transfer in progress.
REQ-019 The bus SHALL be idle for at least one cycle (IDLE) between consecutive transfers.

Reset
REQ-020 While rst=1, the block SHALL force state=IDLE, lastGnt=1 (CPU wins the first tie), counter=0, all latched registers=0, and every output=0.
REQ-021 If rst is asserted mid-transfer, the transfer SHALL be aborted with no Ack issued; after rst is released, a request still held SHALL be arbitrated from IDLE.

Verification
REQ-022 The bench SHALL cover: CPU load from 0x10010004, bank0, busRData=0xDEADBEEF -> cpuAck at cycle 2, cpuRData=0xDEADBEEF, cpuErr=0, dmaAck=0.
REQ-023 The bench SHALL cover: DMA store to 0xFFFF0008, bank2 -> busWrite=1 for 4 cycles, busWData=dmaWData, dmaAck at cycle 5, dmaRData=0.
REQ-024 The bench SHALL cover: cpuReq and dmaReq both held high after reset -> grant order CPU, DMA, CPU, with one IDLE cycle between transfers.
REQ-025 The bench SHALL cover: CPU load from 0x00000000 with decInvalid=1 -> cpuAck at cycle 2 with cpuErr=1, and busRead high for 1 cycle only.
REQ-026 The bench SHALL cover: VGA load from 0x0000B800, bank1, with cpuAddr changed during ACCESS -> busAddr stays 0x0000B800, Ack at cycle 3.
REQ-027 The bench SHALL cover: rst pulsed during a bank2 ACCESS -> no Ack, all outputs 0, busy=0; with req still held, the transfer restarts and acks 5 cycles after the first IDLE.
